// File: rtl/ac97_frame_tx_if.sv
// ac97_frame_tx_if
// Bundles the PCM input side and the AC97 serial output side of the
// frame serializer.
//   sample     : 16-bit PCM sample from the song memory (to DUT)
//   mute       : 1 = send zero PCM in the next frame (to DUT)
//   sample_req : one-cycle pulse, current sample consumed (from DUT)
//   sync       : AUDIO_SYNC (from DUT)
//   sdata_out  : AUDIO_SDATA_OUT, MSB first (from DUT)
//   init_done  : codec register writes finished, sticky (from DUT)
//   dbg_state  : current frame-level FSM state (from DUT)
// Handshake: there is no valid/ready pair. The DUT latches sample/mute on
// the edge presenting frame bit 255; sample_req marks bit 0 of every PCM
// frame, after which upstream has 255 cycles to present the next sample.
interface ac97_frame_tx_if;
  logic [15:0] sample;
  logic        mute;
  logic        sample_req;
  logic        sync;
  logic        sdata_out;
  logic        init_done;
  logic [1:0]  dbg_state;

  modport slave (
    input  sample, mute,
    output sample_req, sync, sdata_out, init_done, dbg_state
  );

  modport master (
    output sample, mute,
    input  sample_req, sync, sdata_out, init_done, dbg_state
  );
endinterface

// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx
// AC97 output-frame serializer running on AUDIO_BIT_CLK. After reset it
// sends WAIT_FRAMES idle frames, then three codec register writes
// (master, headphone, PCM volume), then one PCM sample per frame on both
// the left and right slots forever.
// Ports:
//   clk : AUDIO_BIT_CLK, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : ac97_frame_tx_if.slave (sample, mute in; sample_req, sync,
//         sdata_out, init_done, dbg_state out)
module ac97_frame_tx #(
  parameter int          WAIT_FRAMES = 4,
  parameter logic [15:0] MASTER_VOL  = 16'h0000,
  parameter logic [15:0] HP_VOL      = 16'h0000,
  parameter logic [15:0] PCM_VOL     = 16'h0808
) (
  input  logic            clk,
  input  logic            rst,
  ac97_frame_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_CMD  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_CNT = 16'(WAIT_FRAMES);

  // r_cnt is the index of the bit that the next rising edge presents.
  logic [7:0]  r_cnt;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_sample;
  logic        r_mute;

  logic        r_sync, r_sdata, r_req, r_init_done;

  logic        w_frame_end;
  logic        w_is_cmd, w_is_pcm;
  logic [6:0]  w_reg;
  logic [15:0] w_data;
  logic [15:0] w_pcm;
  logic [95:0] w_frame;
  logic        w_bit;

  assign w_frame_end = (r_cnt == 8'd255);

  // The state register holds the kind of the frame being (or about to be)
  // sent. It advances on the edge presenting bit 255, so the new value is
  // in place for the edge presenting bit 0 of the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_frame_cnt <= 16'd0;
      r_idx       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_idx_nxt       = r_idx;
    if (w_frame_end) begin
      case (r_state)
        S_WAIT: begin
          if (r_frame_cnt < WAIT_CNT) w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          // 17-bit compare so WAIT_FRAMES = 65535 cannot wrap.
          if (({1'b0, r_frame_cnt} + 17'd1) >= {1'b0, WAIT_CNT}) w_state_nxt = S_CMD;
        end
        S_CMD: begin
          if (r_idx == 2'd2) w_state_nxt = S_RUN;
          else               w_idx_nxt   = r_idx + 2'd1;
        end
        S_RUN:   w_state_nxt = S_RUN;
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  // Command table; r_idx only moves at frame end so it is stable in-frame.
  always_comb begin
    w_reg  = 7'h18;
    w_data = PCM_VOL;
    case (r_idx)
      2'd0: begin w_reg = 7'h02; w_data = MASTER_VOL; end
      2'd1: begin w_reg = 7'h04; w_data = HP_VOL;     end
      default: begin w_reg = 7'h18; w_data = PCM_VOL; end
    endcase
  end

  assign w_is_cmd = (r_state == S_CMD);
  assign w_is_pcm = (r_state == S_RUN);
  assign w_pcm    = r_mute ? 16'h0000 : r_sample;

  // Bits 0..95 of the frame, bit 0 at the MSB: tag, slot1..slot4.
  assign w_frame = {
    1'b1, w_is_cmd, w_is_cmd, w_is_pcm, w_is_pcm, 11'd0,
    (w_is_cmd ? {1'b0, w_reg, 12'd0} : 20'd0),
    (w_is_cmd ? {w_data, 4'd0}       : 20'd0),
    (w_is_pcm ? {w_pcm, 4'd0}        : 20'd0),
    (w_is_pcm ? {w_pcm, 4'd0}        : 20'd0)
  };

  assign w_bit = (r_cnt < 8'd96) ? w_frame[7'd95 - r_cnt[6:0]] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_sample    <= 16'd0;
      r_mute      <= 1'b0;
      r_sync      <= 1'b0;
      r_sdata     <= 1'b0;
      r_req       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 8'd1;
      r_sync  <= (r_cnt < 8'd16);
      r_sdata <= w_bit;
      r_req   <= (r_cnt == 8'd0) && w_is_pcm;
      if ((r_cnt == 8'd0) && w_is_pcm) r_init_done <= 1'b1;
      if (w_frame_end) begin
        r_sample <= bus.sample;
        r_mute   <= bus.mute;
      end
    end
  end

  assign bus.sync       = r_sync;
  assign bus.sdata_out  = r_sdata;
  assign bus.sample_req = r_req;
  assign bus.init_done  = r_init_done;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb_ac97_frame_tx
// Captures whole 256-bit frames off sdata_out and compares each against a
// frame built from the frame number and the sample/mute in effect at the
// previous frame end.
module tb_ac97_frame_tx;

  localparam int WAIT_FRAMES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ac97_frame_tx_if bus();

  ac97_frame_tx #(
    .WAIT_FRAMES (WAIT_FRAMES),
    .MASTER_VOL  (16'h0000),
    .HP_VOL      (16'h0000),
    .PCM_VOL     (16'h0808)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          frame_no;
  logic [15:0] lat_s;
  logic        lat_m;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (frame %0d)", name, act, exp, frame_no);
    end
  endtask

  // Frame f after reset: idle, command (index f-WAIT) or PCM.
  // Returns {tag, slot1, slot2, slot3, slot4}.
  function automatic logic [95:0] model_frame(input int f, input logic [15:0] s, input logic m);
    logic [15:0] tag;
    logic [19:0] s1, s2, s3;
    logic [6:0]  regs [3];
    logic [15:0] vals [3];
    regs = '{7'h02, 7'h04, 7'h18};
    vals = '{16'h0000, 16'h0000, 16'h0808};
    tag = 16'h8000; s1 = '0; s2 = '0; s3 = '0;
    if (f >= WAIT_FRAMES && f < WAIT_FRAMES + 3) begin
      tag = 16'hE000;
      s1  = {1'b0, regs[f - WAIT_FRAMES], 12'h000};
      s2  = {vals[f - WAIT_FRAMES], 4'h0};
    end else if (f >= WAIT_FRAMES + 3) begin
      tag = 16'h9800;
      s3  = m ? 20'h0 : {s, 4'h0};
    end
    return {tag, s1, s2, s3, s3};
  endfunction

  // Runs one full frame; at bit chg_bit (after sampling) the inputs are
  // switched to ns/nm. Returns the captured slot3.
  task automatic run_frame(input int chg_bit, input logic [15:0] ns, input logic nm,
                           output logic [19:0] slot3);
    logic [255:0] fb;
    logic [95:0]  exp;
    int sync_in, sync_out, req_cnt, init_cnt, tail_ones;
    logic req0, pcm;
    logic [15:0] snap_s;
    logic snap_m;
    sync_in = 0; sync_out = 0; req_cnt = 0; init_cnt = 0; tail_ones = 0; req0 = 0;
    snap_s = bus.sample; snap_m = bus.mute;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      fb[255 - j] = bus.sdata_out;
      if (bus.sync) begin
        if (j < 16) sync_in++; else sync_out++;
      end
      if (bus.sample_req) begin
        req_cnt++;
        if (j == 0) req0 = 1'b1;
      end
      if (bus.init_done) init_cnt++;
      if (j == chg_bit) begin
        bus.sample = ns;
        bus.mute   = nm;
      end
      if (j == 254) begin
        snap_s = bus.sample;
        snap_m = bus.mute;
      end
    end
    for (int k = 0; k < 160; k++) if (fb[k]) tail_ones++;
    exp = model_frame(frame_no, lat_s, lat_m);
    pcm = (frame_no >= WAIT_FRAMES + 3);
    check("tag",   32'(fb[255:240]), 32'(exp[95:80]));
    check("slot1", 32'(fb[239:220]), 32'(exp[79:60]));
    check("slot2", 32'(fb[219:200]), 32'(exp[59:40]));
    check("slot3", 32'(fb[199:180]), 32'(exp[39:20]));
    check("slot4", 32'(fb[179:160]), 32'(exp[19:0]));
    check("tail_zero", 32'(tail_ones), 32'd0);
    check("sync", 32'(sync_in * 1000 + sync_out), 32'd16000);
    check("sample_req", 32'(req_cnt * 2 + int'(req0)), pcm ? 32'd3 : 32'd0);
    check("init_done", 32'(init_cnt), pcm ? 32'd256 : 32'd0);
    slot3 = fb[199:180];
    lat_s = snap_s;
    lat_m = snap_m;
    frame_no++;
  endtask

  task automatic model_reset();
    frame_no = 0;
    lat_s    = 16'h0000;
    lat_m    = 1'b0;
  endtask

  typedef struct {
    int          chg_bit;
    logic [15:0] sample;
    logic        mute;
    logic [19:0] exp_next;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [19:0] s3;
    tbl[0] = '{60,  16'h1234, 1'b0, 20'h12340};
    tbl[1] = '{200, 16'hBEEF, 1'b1, 20'h00000};
    tbl[2] = '{10,  16'h0001, 1'b0, 20'h00010};
    tbl[3] = '{254, 16'hFFFF, 1'b0, 20'hFFFF0};
    tbl[4] = '{255, 16'h8000, 1'b0, 20'hFFFF0};
    tbl[5] = '{100, 16'h8000, 1'b0, 20'h80000};

    bus.sample = 16'h0000;
    bus.mute   = 1'b0;
    model_reset();

    // reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sync",      32'(bus.sync),       32'd0);
    check("rst_sdata",     32'(bus.sdata_out),  32'd0);
    check("rst_req",       32'(bus.sample_req), 32'd0);
    check("rst_init_done", 32'(bus.init_done),  32'd0);
    rst = 1'b0;

    // idle + command frames; A5C3 present before the last command frame ends
    for (int f = 0; f < WAIT_FRAMES + 3; f++) run_frame(200, 16'hA5C3, 1'b0, s3);
    run_frame(300, 16'h0000, 1'b0, s3);
    check("first_pcm", 32'(s3), 32'hA5C30);

    // table-driven input changes, slot3 checked one frame later
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].chg_bit, tbl[i].sample, tbl[i].mute, s3);
      exp_q.push_back(tbl[i].exp_next);
      if (i > 0) check("tbl_slot", 32'(s3), 32'(exp_q.pop_front()));
    end
    run_frame(300, 16'h0000, 1'b0, s3);
    check("tbl_slot", 32'(s3), 32'(exp_q.pop_front()));

    // random samples, mute and change points
    for (int i = 0; i < 20; i++) begin
      run_frame(int'($urandom_range(0, 255)), 16'($urandom),
                ($urandom_range(0, 3) == 0), s3);
    end

    // asynchronous reset mid-PCM-frame
    repeat (101) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sync",      32'(bus.sync),       32'd0);
    check("arst_sdata",     32'(bus.sdata_out),  32'd0);
    check("arst_req",       32'(bus.sample_req), 32'd0);
    check("arst_init_done", 32'(bus.init_done),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < WAIT_FRAMES + 5; f++) begin
      run_frame(int'($urandom_range(0, 254)), 16'($urandom), 1'b0, s3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac97_frame_tx.md
Name: ac97_frame_tx

Overview:
- AC97 output-frame serializer. It runs on the codec bit clock and sits directly downstream of the song memory.
- It consumes 16-bit PCM samples from the memory's data output and emits AUDIO_SYNC / AUDIO_SDATA_OUT.
- After reset it programs the codec volume registers, then streams one sample per frame on both channels.
- It pulses sample_req once per PCM frame so the address register in ctrl can advance.

Parameters:
- WAIT_FRAMES, 4, idle frames after reset before the first register write (codec settling). Range 1..65535.
- MASTER_VOL, 16'h0000, data written to codec reg 0x02.
- HP_VOL, 16'h0000, data written to codec reg 0x04.
- PCM_VOL, 16'h0808, data written to codec reg 0x18.

Ports:
- clk  in  1  AUDIO_BIT_CLK (12.288 MHz); all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample  in  16  PCM sample {e,d} from the song memory.
- mute  in  1  1 = send zero PCM (slots still valid).
- sample_req  out  1  one-cycle pulse: current sample consumed, advance address.
- sync  out  1  AUDIO_SYNC.
- sdata_out  out  1  AUDIO_SDATA_OUT, MSB first.
- init_done  out  1  high once all three codec writes have been sent; sticky until rst.

Behaviour:
- Reset values: sync=0, sdata_out=0, sample_req=0, init_done=0. Internal: bit counter=0, state=S_WAIT, frame counter=0, command index=0, latched sample=0.
- Reset is asynchronous. Asserting it mid-frame forces every output low immediately and restarts initialization from S_WAIT.
- Frame timing:
  - The first rising edge after rst deasserts presents frame bit 0.
  - Each subsequent edge presents the next bit. A frame is 256 bits; after bit 255 the counter wraps to bit 0.
  - All outputs are registered.
  - sync=1 while bits 0..15 are presented, 0 otherwise.
- Frame layout (frame bit index):
  - 0..15: tag. Tag bit15 = 1 (frame valid). Bit14 = bit13 = command frame. Bit12 = bit11 = PCM frame. Bits 10..0 = 0.
  - 16..35: slot1. Bit19 = 0 (write), bits 18..12 = register index, bits 11..0 = 0. All zero in non-command frames.
  - 36..55: slot2. Bits 19..4 = write data, bits 3..0 = 0. All zero in non-command frames.
  - 56..75: slot3 (left), {pcm, 4'h0}. 76..95: slot4 (right), same value.
  - pcm = latched sample, or 0 if mute was latched as 1. Slots 3 and 4 are zero in non-PCM frames.
  - 96..255: zero.
- Latching:
  - sample and mute are captured on the edge that presents bit 255 and are used for the following frame.
  - Input changes at any other time do not affect the frame in flight.
  - Command contents are fixed at bit 0 of each frame.
- State machine (transitions take effect at frame boundaries, i.e. the edge presenting bit 0):
  - S_WAIT: WAIT_FRAMES idle frames (tag 0x8000). Then go to S_CMD.
  - S_CMD: three consecutive command frames, tag 0xE000:
    - idx0: reg 0x02 / MASTER_VOL.
    - idx1: reg 0x04 / HP_VOL.
    - idx2: reg 0x18 / PCM_VOL.
    - After idx2 go to S_RUN.
  - S_RUN: every frame is a PCM frame, tag 0x9800. Remain here until rst.
- init_done rises on the edge presenting bit 0 of the first S_RUN frame.
- sample_req is high exactly during the bit-0 cycle of each S_RUN frame and is never asserted in S_WAIT or S_CMD.
- Consequence of the sample_req / latch timing:
  - The first PCM frame plays the sample present at the end of the last command frame, i.e. address 0.
  - Upstream has 255 cycles after each sample_req to present the next sample.
- Width rules:
  - Bit counter is 8 bits with natural wrap.
  - Frame counter is 16 bits and saturates at WAIT_FRAMES.
  - Command index is 2 bits.

Test Plan:
1. Reset release, WAIT_FRAMES=4 -> sync high for exactly 16 cycles every 256 cycles, starting on the first edge. sdata_out=1 on bit 0. Frames 0..3 tag 0x8000, all slots 0.
2. Init sequence -> frame 4 tag 0xE000, slot1 0x02000, slot2 0x00000. Frame 5 slot1 0x04000. Frame 6 slot1 0x18000, slot2 0x08080. sample_req=0 and init_done=0 throughout frames 0..6.
3. sample=16'hA5C3 held -> frame 7: tag 0x9800, slot3=slot4=0xA5C30, slots 5..12 zero, init_done=1. sample_req single-cycle pulse at bit 0 of frames 7, 8, 9...
4. sample changed to 16'h1234 at bit 60 of a PCM frame -> current frame slot4 still 0xA5C30. Next frame slot3=slot4=0x12340.
5. mute=1 before bit 255 -> next frame tag 0x9800, slot3=slot4=0x00000, sample_req still pulses.
6. rst asserted at bit 100 of a PCM frame -> sync, sdata_out, sample_req and init_done go to 0 without waiting for a clock edge. After release: 4 idle frames and 3 command frames repeat, then PCM resumes.
